// File: rtl/alien1_sprite_ctrl.sv
// Alien1 sprite controller: beam-to-ROM address generation with a
// registered hit pipe, plus the frame-paced march/drop movement FSM.
module alien1_sprite_ctrl #(
  parameter int SPR_W   = 31,
  parameter int SPR_H   = 26,
  parameter int X_START = 64,
  parameter int Y_START = 32,
  parameter int X_MAX   = 609,
  parameter int Y_MAX   = 454,
  parameter int X_STEP  = 2,
  parameter int Y_DROP  = 8,
  parameter int FRM_DIV = 2
) (
  input  logic       i_clk2,
  input  logic       i_rst,
  input  logic [9:0] i_xpos,
  input  logic [9:0] i_ypos,
  input  logic       i_active,
  input  logic       i_frame,
  input  logic       i_pause,
  output logic [9:0] o_A1addr,
  output logic       o_A1hit,
  output logic [9:0] o_A1x,
  output logic [9:0] o_A1y
);

  localparam int CW = (FRM_DIV > 1) ? $clog2(FRM_DIV) : 1;

  typedef enum logic [1:0] {
    S_RIGHT,
    S_LEFT,
    S_DROP_L,
    S_DROP_R
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [9:0]    w_x_nx;
  logic [9:0]    w_y_nx;
  logic [CW-1:0] r_fcnt;
  logic          w_run;
  logic          w_step;

  logic [9:0]  r_addr;
  logic        r_hit1;
  logic        r_hit2;

  logic [10:0] w_xe;
  logic [10:0] w_ye;
  logic [10:0] w_ax;
  logic [10:0] w_ay;
  logic [10:0] w_xhi;
  logic [10:0] w_yhi;
  logic        w_inbox;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [9:0]  w_row;
  logic [9:0]  w_addr;

  logic [10:0] w_xr;
  logic [10:0] w_yd;
  logic        w_xr_ovf;
  logic        w_xl_unf;
  logic        w_yd_ovf;

  // ---------------- pixel path ----------------
  assign w_xe  = {1'b0, i_xpos};
  assign w_ye  = {1'b0, i_ypos};
  assign w_ax  = {1'b0, r_x};
  assign w_ay  = {1'b0, r_y};
  assign w_xhi = w_ax + 11'(SPR_W - 1);
  assign w_yhi = w_ay + 11'(SPR_H - 1);

  assign w_inbox = i_active
                 & (w_xe >= w_ax) & (w_xe <= w_xhi)
                 & (w_ye >= w_ay) & (w_ye <= w_yhi);

  // Differences are only consumed when inside the box, so no underflow.
  assign w_dx   = i_xpos - r_x;
  assign w_dy   = i_ypos - r_y;
  assign w_row  = w_dy * 10'(SPR_W);
  assign w_addr = w_inbox ? (w_row + w_dx) : 10'd0;

  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_hit1 <= 1'b0;
      r_hit2 <= 1'b0;
    end else begin
      r_addr <= w_addr;
      r_hit1 <= w_inbox;
      r_hit2 <= r_hit1;
    end
  end

  assign o_A1addr = r_addr;
  assign o_A1hit  = r_hit2;

  // ---------------- frame pacing ----------------
  assign w_run  = i_frame & ~i_pause;
  assign w_step = w_run & (r_fcnt == CW'(FRM_DIV - 1));

  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      r_fcnt <= '0;
    end else if (w_run) begin
      r_fcnt <= w_step ? '0 : r_fcnt + CW'(1);
    end
  end

  // ---------------- movement FSM ----------------
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RIGHT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  assign w_xr     = w_ax + 11'(X_STEP);
  assign w_yd     = w_ay + 11'(Y_DROP);
  assign w_xr_ovf = w_xr > 11'(X_MAX);
  assign w_xl_unf = w_ax < 11'(X_STEP);
  assign w_yd_ovf = w_yd > 11'(Y_MAX);

  always_comb begin
    w_state_nx = r_state;
    if (w_step) begin
      unique case (r_state)
        S_RIGHT:  if (w_xr_ovf) w_state_nx = S_DROP_L;
        S_LEFT:   if (w_xl_unf) w_state_nx = S_DROP_R;
        S_DROP_L: w_state_nx = S_LEFT;
        S_DROP_R: w_state_nx = S_RIGHT;
      endcase
    end
  end

  always_comb begin
    w_x_nx = r_x;
    w_y_nx = r_y;
    unique case (r_state)
      S_RIGHT: begin
        w_x_nx = w_xr_ovf ? 10'(X_MAX) : w_xr[9:0];
      end
      S_LEFT: begin
        w_x_nx = w_xl_unf ? 10'd0 : r_x - 10'(X_STEP);
      end
      S_DROP_L, S_DROP_R: begin
        w_y_nx = w_yd_ovf ? 10'(Y_START) : w_yd[9:0];
      end
    endcase
  end

  // Position only moves on a step, which only happens with i_frame high.
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      r_x <= 10'(X_START);
      r_y <= 10'(Y_START);
    end else if (w_step) begin
      r_x <= w_x_nx;
      r_y <= w_y_nx;
    end
  end

  assign o_A1x = r_x;
  assign o_A1y = r_y;

endmodule

// File: tb/tb_alien1_sprite_ctrl.sv
// Scoreboard bench for alien1_sprite_ctrl: queued pixel expectations,
// directed movement and reset checks.
module tb_alien1_sprite_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       act;
  logic       frame;
  logic       pause;
  logic [9:0] addr;
  logic       hit;
  logic [9:0] ax;
  logic [9:0] ay;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int         tag;
    logic       hit;
    logic [9:0] addr;
  } exp_t;

  exp_t q_addr[$];
  exp_t q_hit[$];

  int hit_cnt = 0;
  int seen[0:1023];
  logic [9:0] prev_addr = '0;

  alien1_sprite_ctrl dut (
    .i_clk2   (clk),
    .i_rst    (rst),
    .i_xpos   (xpos),
    .i_ypos   (ypos),
    .i_active (act),
    .i_frame  (frame),
    .i_pause  (pause),
    .o_A1addr (addr),
    .o_A1hit  (hit),
    .o_A1x    (ax),
    .o_A1y    (ay)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: addr for a vector drives out one edge later, hit two edges later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q_addr.size() > 0 && q_addr[0].tag < cyc - 1) begin
        e = q_addr.pop_front();
        check("addr_stale", 0, 1);
      end
      if (q_addr.size() > 0 && q_addr[0].tag == cyc - 1) begin
        e = q_addr.pop_front();
        check("addr", 32'(addr), 32'(e.addr));
      end
      while (q_hit.size() > 0 && q_hit[0].tag < cyc - 2) begin
        e = q_hit.pop_front();
        check("hit_stale", 0, 1);
      end
      if (q_hit.size() > 0 && q_hit[0].tag == cyc - 2) begin
        e = q_hit.pop_front();
        check("hit", 32'(hit), 32'(e.hit));
      end
      if (hit === 1'b1) begin
        hit_cnt++;
        seen[prev_addr]++;
      end
      prev_addr = addr;
    end
  end

  task automatic pix(input int x, input int y, input logic a,
                     input logic eh, input int ea);
    exp_t e;
    xpos = 10'(x);
    ypos = 10'(y);
    act  = a;
    e.tag  = cyc;
    e.hit  = eh;
    e.addr = 10'(ea);
    q_addr.push_back(e);
    q_hit.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    act = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse();
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
  endtask

  task automatic step();
    frame = 1'b1;
    repeat (2) @(negedge clk);
    frame = 1'b0;
  endtask

  typedef struct {
    int   x;
    int   y;
    logic a;
    logic h;
    int   ad;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    int bad;
    logic in;
    tbl[0] = '{64, 32, 1'b1, 1'b1, 0};
    tbl[1] = '{94, 57, 1'b1, 1'b1, 805};
    tbl[2] = '{95, 57, 1'b1, 1'b0, 0};
    tbl[3] = '{94, 58, 1'b1, 1'b0, 0};
    tbl[4] = '{64, 32, 1'b0, 1'b0, 0};
    tbl[5] = '{63, 32, 1'b1, 1'b0, 0};
    tbl[6] = '{64, 31, 1'b1, 1'b0, 0};
    tbl[7] = '{65, 33, 1'b1, 1'b1, 32};
    tbl[8] = '{94, 32, 1'b1, 1'b1, 30};
    tbl[9] = '{64, 57, 1'b1, 1'b1, 775};

    rst = 1'b1;
    xpos = '0;
    ypos = '0;
    act = 1'b0;
    frame = 1'b0;
    pause = 1'b0;
    #5;
    check("rst_addr", 32'(addr), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_x", 32'(ax), 64);
    check("rst_y", 32'(ay), 32);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) pix(tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].h, tbl[i].ad);
    drain();

    // Sweep the sprite and a margin around it.
    hit_cnt = 0;
    for (int i = 0; i < 1024; i++) seen[i] = 0;
    for (int y = 30; y <= 59; y++) begin
      for (int x = 62; x <= 96; x++) begin
        in = (x >= 64) && (x <= 94) && (y >= 32) && (y <= 57);
        pix(x, y, 1'b1, in, in ? (y - 32) * 31 + (x - 64) : 0);
      end
    end
    drain();
    check("sweep_hits", 32'(hit_cnt), 806);
    bad = 0;
    for (int i = 0; i < 806; i++) if (seen[i] != 1) bad++;
    check("sweep_addr_once", 32'(bad), 0);

    pulse(); check("frm1_x", 32'(ax), 64);
    pulse(); check("frm2_x", 32'(ax), 66);
    pulse(); check("frm3_x", 32'(ax), 66);
    pulse(); check("frm4_x", 32'(ax), 68);
    pause = 1'b1;
    pulse(); check("pause1_x", 32'(ax), 68);
    pulse(); check("pause2_x", 32'(ax), 68);
    pause = 1'b0;
    pulse(); check("resume1_x", 32'(ax), 68);
    pulse(); check("resume2_x", 32'(ax), 70);

    n = 0;
    while (ax != 10'd609 && n < 1000) begin
      step();
      n++;
    end
    check("steps_to_right", 32'(n), 270);
    check("edge_y", 32'(ay), 32);
    step();
    check("dropl_x", 32'(ax), 609);
    check("dropl_y", 32'(ay), 40);
    step();
    check("left_x", 32'(ax), 607);
    check("left_y", 32'(ay), 40);

    n = 0;
    while (ay != 10'd448 && n < 30000) begin
      step();
      n++;
    end
    check("reach448_y", 32'(ay), 448);
    check("reach448_x", 32'(ax), 0);
    step();
    check("row448_x", 32'(ax), 2);
    n = 0;
    while (ay == 10'd448 && n < 400) begin
      step();
      n++;
    end
    check("wrap_y", 32'(ay), 32);
    check("wrap_x", 32'(ax), 609);
    step();
    check("wrap_dir_x", 32'(ax), 607);
    check("wrap_dir_y", 32'(ay), 32);

    // Mid-cycle reset with the hit pipe full.
    xpos = 10'd607;
    ypos = 10'd32;
    act  = 1'b1;
    repeat (2) @(negedge clk);
    check("prerst_hit", 32'(hit), 1);
    #5;
    rst = 1'b1;
    #1;
    check("mrst_hit", 32'(hit), 0);
    check("mrst_addr", 32'(addr), 0);
    check("mrst_x", 32'(ax), 64);
    check("mrst_y", 32'(ay), 32);
    act = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_hit", 32'(hit), 0);
    step();
    check("postrst_x", 32'(ax), 66);
    check("postrst_y", 32'(ay), 32);

    drain();
    check("queue_empty", 32'(q_addr.size() + q_hit.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
